dmem_bank: RTL and testbench
============================

Name: dmem_bank

Overview:
- Parametrised, byte-addressable data memory for the core's load/store path.
- Single-outstanding request/response handshake; byte-enable writes; synchronous read.
- Flags misaligned and out-of-range accesses as errors.
- Optional post-reset sweep that clears the whole array.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request can be accepted this cycle.
- req_we_i  in  1  0 = read, 1 = write.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_be_i  in  DATA_W/8  byte enables; bit n enables byte lane n.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- resp_err_o  out  1  access was misaligned or out of range.
- busy_o  out  1  clear sweep in progress.

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Derived constants:
  - OFS_W = log2(DATA_W/8).
  - IDX_W = log2(DEPTH).
  - Word index = req_addr_i[OFS_W+IDX_W-1:OFS_W].
- Reset values: resp_valid_o=0, resp_rdata_o=0, resp_err_o=0. req_ready_o and busy_o depend on DMEM_CLEAR_EN (see Optional Feature).
- State machine (dmem_state_e):
  - CLEAR: sweep counter 0..DEPTH-1 writes zeros, one word per cycle. Goes to IDLE after the DEPTH-1 write.
  - IDLE: accepts requests.
- Handshake:
  - req_ready_o = (state==IDLE) && (!resp_valid_o || resp_ready_i).
  - A request is accepted on a cycle where req_valid_i && req_ready_o.
  - The response is valid on the next cycle (latency 1) and is held stable until resp_ready_i is sampled high.
  - Back-to-back requests are allowed: the response handoff and a new accept may happen in the same cycle, giving full throughput.
- Error checks:
  - err = (addr[OFS_W-1:0] != 0) || (addr >> (OFS_W+IDX_W) != 0).
  - On error: no array write, resp_rdata_o=0, resp_err_o=1.
- Write:
  - Only lanes with req_be_i[n]=1 are updated.
  - be=0 is legal: no change, resp_err_o=0.
  - Response carries rdata=0.
- Read: returns the full word regardless of req_be_i.
- A read immediately following a write to the same address returns the newly written data; the array must support this ordering.
- resp_valid_o falls when resp_ready_i=1 and no new request is accepted that cycle.
- Reset mid-operation:
  - Any pending response is dropped (resp_valid_o=0 next cycle).
  - An in-progress sweep restarts from 0 (DMEM_CLEAR_EN only).
  - Array contents are otherwise untouched.
- Requests arriving during CLEAR are stalled via req_ready_o=0 and are not dropped; the requester holds them.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined:
  - Reset enters CLEAR; busy_o=1 and req_ready_o=0 for exactly DEPTH cycles after rst_i deasserts.
  - After that, every word reads 0.
- Undefined:
  - Reset enters IDLE directly; busy_o is tied 0 and req_ready_o=1 on the first cycle after reset.
  - Array contents are unspecified until written.

Decomposition:
- Package dmem_pkg holds:
  - dmem_state_e {CLEAR, IDLE}.
  - Default width/depth localparams.
  - Function clog2-safe offset width.
- Sub-module dmem_array:
  - Storage only: DEPTH x DATA_W.
  - Byte-enable synchronous write, synchronous read.
  - Write port shared between the sweep and requests, muxed in the parent.
- dmem_bank holds the FSM, error checks and the response register.

Test Plan:
- Clear sweep (DMEM_CLEAR_EN, DEPTH=1024): release reset; expect busy_o=1 for 1024 cycles, then req_ready_o=1. Read 0x0000_0FFC → rdata=0, err=0.
- Byte-enable write: write 0xDEADBEEF to 0x10 with be=4'hF. Then write 0x000000AA to 0x10 with be=4'h1. Read 0x10 → 0xDEADBEAA.
- Errors:
  - Read 0x12 → err=1, rdata=0.
  - Write to 0x1000 with DEPTH=1024 → err=1.
  - Subsequent read of 0x0 is unchanged.
- Backpressure: issue a read, hold resp_ready_i=0 for 5 cycles. Expect resp_valid_o and rdata stable and req_ready_o=0 throughout. Raise resp_ready_i and accept the next request in the same cycle.
- Streaming: 8 back-to-back writes to 0x0..0x1C, then 8 back-to-back reads with resp_ready_i=1. Expect one response per cycle with matching data.
- Reset mid-operation: assert rst_i with a pending response → resp_valid_o=0 next cycle. With DMEM_CLEAR_EN, assert rst_i mid-sweep → sweep restarts and busy_o lasts DEPTH cycles from reset release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, default sizes and helpers for the dmem_bank data memory.
package dmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_e;

  // Byte-offset bits inside one word; an 8-bit word has no offset field.
  function automatic int ofs_width(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake between a load/store requester and dmem_bank.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic [DATA_W/8-1:0]   req_be_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_W-1:0]     resp_rdata_o;
  logic                  resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage for dmem_bank: byte-enable synchronous write, registered read.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the sweep or requests change them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int n = 0; n < BE_W; n++) begin
        if (be_i[n]) mem[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/dmem_bank.sv
// Byte-addressable data memory with single-outstanding request/response handshake.
// Define DMEM_CLEAR_EN to zero the whole array in a sweep after every reset.
//
// state | meaning
// CLEAR | sweep writes zero to one word per cycle; requests stalled
// IDLE  | requests accepted whenever the response slot is free
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic  clk_i,
  input  logic  rst_i,
  dmem_if.slave bus,
  output logic  busy_o
);

  localparam int OFS_W = ofs_width(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS_W) - 1);

  dmem_state_e       state_q, state_d;
  logic              resp_valid_q, resp_err_q, resp_rd_q;
  logic              accept, req_err, wr_req, rd_req;
  logic              sweep_we, sweep_last;
  logic [IDX_W-1:0]  sweep_idx, req_idx, arr_waddr;
  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

`ifdef DMEM_CLEAR_EN
  localparam dmem_state_e RST_STATE = CLEAR;
  logic [IDX_W-1:0] sweep_cnt_q;

  // Reset restarts the sweep from word 0; the counter wraps back to 0 on exit.
  always_ff @(posedge clk_i) begin
    if (rst_i)                sweep_cnt_q <= '0;
    else if (state_q == CLEAR) sweep_cnt_q <= sweep_cnt_q + 1'b1;
  end

  assign sweep_last = (sweep_cnt_q == IDX_W'(DEPTH - 1));
  assign sweep_idx  = sweep_cnt_q;
`else
  localparam dmem_state_e RST_STATE = IDLE;
  assign sweep_last = 1'b1;
  assign sweep_idx  = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (sweep_last) state_d = IDLE;
      IDLE:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o          = 1'b0;
    bus.req_ready_o = 1'b0;
    sweep_we        = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_o   = 1'b1;
        sweep_we = !rst_i;
      end
      IDLE: bus.req_ready_o = !resp_valid_q || bus.resp_ready_i;
    endcase
  end

  // Address 0x1000 would alias onto word 0 without the upper-bits check.
  assign req_err = ((bus.req_addr_i & OFS_MASK) != '0) ||
                   ((bus.req_addr_i >> (OFS_W + IDX_W)) != '0);
  assign req_idx = bus.req_addr_i[OFS_W +: IDX_W];
  assign accept  = bus.req_valid_i && bus.req_ready_o && !rst_i;
  assign wr_req  = accept && bus.req_we_i && !req_err;
  assign rd_req  = accept && !bus.req_we_i && !req_err;

  assign arr_we    = sweep_we || wr_req;
  assign arr_be    = sweep_we ? '1 : bus.req_be_i;
  assign arr_waddr = sweep_we ? sweep_idx : req_idx;
  assign arr_wdata = sweep_we ? '0 : bus.req_wdata_i;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (rd_req),
    .raddr_i (req_idx),
    .rdata_o (arr_rdata)
  );

  // A new accept overrides the handoff, which keeps back-to-back throughput.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= req_err;
      resp_rd_q    <= !bus.req_we_i && !req_err;
    end else if (bus.resp_ready_i) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end
  end

  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_rdata_o = resp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench for dmem_bank: directed steps plus randomized traffic against a word-array model.
module tb_dmem_bank;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o;

  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit ref_err(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  task automatic idle_inputs();
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_be_i     = '0;
    bus.resp_ready_i = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (bus.req_ready_o !== 1'b1 && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    check_bit("req_ready_wait", bus.req_ready_o, 1'b1);
  endtask

  // One complete transaction: accept, hold the response for `stall` cycles, hand it off.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int stall,
                        output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    bit          exp_e;
    exp_e = ref_err(addr);
    exp_d = 32'h0;
    if (!exp_e) begin
      if (!we) exp_d = mem_m[addr / 4];
      else
        for (int l = 0; l < 4; l++)
          if (be[l]) mem_m[addr / 4][8*l +: 8] = wdata[8*l +: 8];
    end
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_be_i     = be;
    bus.resp_ready_i = (stall == 0);
    wait_ready();
    tick();
    bus.req_valid_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1;
      check_bit({tag, ".hold_valid"}, bus.resp_valid_o, 1'b1);
      check({tag, ".hold_rdata"}, bus.resp_rdata_o, exp_d);
      check_bit({tag, ".hold_ready"}, bus.req_ready_o, 1'b0);
      tick();
    end
    bus.resp_ready_i = 1'b1;
    #1;
    check_bit({tag, ".valid"}, bus.resp_valid_o, 1'b1);
    check({tag, ".rdata"}, bus.resp_rdata_o, exp_d);
    check_bit({tag, ".err"}, bus.resp_err_o, exp_e);
    got_d = bus.resp_rdata_o;
    got_e = bus.resp_err_o;
    tick();
    check_bit({tag, ".valid_drop"}, bus.resp_valid_o, 1'b0);
  endtask

  task automatic expect_sweep(input string tag);
    int n = 0;
    while (busy_o === 1'b1 && n < 2 * DEPTH) begin
      n++;
      tick();
    end
    check({tag, ".busy_cycles"}, 32'(n), 32'(DEPTH));
    foreach (mem_m[i]) mem_m[i] = 32'h0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, exp1, exp2;
    logic        e, we;
    logic [3:0]  be;

    rst_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check_bit("rst.resp_valid", bus.resp_valid_o, 1'b0);
    check("rst.resp_rdata", bus.resp_rdata_o, 32'h0);
    check_bit("rst.resp_err", bus.resp_err_o, 1'b0);
`ifdef DMEM_CLEAR_EN
    check_bit("rst.busy", busy_o, 1'b1);
    check_bit("rst.ready_low", bus.req_ready_o, 1'b0);
    expect_sweep("sweep");
    #1;
    check_bit("sweep.ready_after", bus.req_ready_o, 1'b1);
    do_req("rd_top", 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 0, d, e);
    check("rd_top.zero", d, 32'h0);
`else
    check_bit("rst.busy", busy_o, 1'b0);
    check_bit("rst.ready", bus.req_ready_o, 1'b1);
`endif

    for (int i = 0; i < 16; i++)
      do_req("init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0, d, e);

    do_req("be_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, d, e);
    do_req("be_lane0", 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 0, d, e);
    do_req("be_read", 1'b0, 32'h10, 32'h0, 4'h0, 0, d, e);
    check("be_merge", d, 32'hDEADBEAA);

    do_req("err_misalign", 1'b0, 32'h12, 32'h0, 4'hF, 0, d, e);
    check_bit("err_misalign.flag", e, 1'b1);
    exp1 = mem_m[0];
    do_req("err_range", 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, d, e);
    check_bit("err_range.flag", e, 1'b1);
    do_req("err_word0", 1'b0, 32'h0, 32'h0, 4'h0, 0, d, e);
    check("err_word0.same", d, exp1);

    exp1 = mem_m[5];
    do_req("be_zero", 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0, d, e);
    do_req("be_zero_rd", 1'b0, 32'h14, 32'h0, 4'h0, 0, d, e);
    check("be_zero.same", d, exp1);

    // Backpressure for 5 cycles, then handoff and a new accept on the same edge.
    exp1 = mem_m[4];
    exp2 = mem_m[5];
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = 32'h10;
    bus.resp_ready_i = 1'b0;
    wait_ready();
    tick();
    bus.req_addr_i = 32'h14;
    for (int s = 0; s < 5; s++) begin
      #1;
      check_bit("bp.valid", bus.resp_valid_o, 1'b1);
      check("bp.rdata", bus.resp_rdata_o, exp1);
      check_bit("bp.ready", bus.req_ready_o, 1'b0);
      tick();
    end
    bus.resp_ready_i = 1'b1;
    #1;
    check_bit("bp.release_ready", bus.req_ready_o, 1'b1);
    check("bp.release_rdata", bus.resp_rdata_o, exp1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    check_bit("bp.next_valid", bus.resp_valid_o, 1'b1);
    check("bp.next_rdata", bus.resp_rdata_o, exp2);
    tick();
    check_bit("bp.drain", bus.resp_valid_o, 1'b0);

    // Streaming: 8 writes then 8 reads, one response every cycle.
    bus.resp_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a  = 32'((i % 8) * 4);
      we = (i < 8);
      d  = $urandom;
      exp1 = we ? 32'h0 : mem_m[a / 4];
      if (we) mem_m[a / 4] = d;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wdata_i = d;
      bus.req_be_i    = 4'hF;
      #1;
      check_bit("stream.ready", bus.req_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      check_bit("stream.valid", bus.resp_valid_o, 1'b1);
      check("stream.rdata", bus.resp_rdata_o, exp1);
    end
    bus.req_valid_i = 1'b0;
    tick();
    check_bit("stream.drain", bus.resp_valid_o, 1'b0);

    for (int t = 0; t < 150; t++) begin
      int unsigned r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      else if (r == 2) a = 32'h8000_0000 | (32'($urandom_range(0, 15)) * 4);
      else             a = 32'($urandom_range(0, 15)) * 4;
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      do_req("rand", we, a, $urandom, be, int'($urandom_range(0, 2)), d, e);
    end

    // Reset with a response pending drops it.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = 32'h8;
    bus.resp_ready_i = 1'b0;
    wait_ready();
    tick();
    bus.req_valid_i = 1'b0;
    check_bit("rst_mid.pending", bus.resp_valid_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    #1;
    check_bit("rst_mid.dropped", bus.resp_valid_o, 1'b0);
`ifdef DMEM_CLEAR_EN
    repeat (300) tick();
    check_bit("rst_sweep.busy_mid", busy_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    expect_sweep("rst_sweep");
`else
    check_bit("rst_mid.ready", bus.req_ready_o, 1'b1);
`endif
    do_req("rst_mid.rd", 1'b0, 32'h8, 32'h0, 4'h0, 0, d, e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
